// File: rtl/cdb_rr_arbiter_pkg.sv
// Shared CDB definitions: default arbiter geometry, broadcast packet layout, index wrap helper.
// The packet layout is common to every CDB consumer (RS, ROB, map table).
package sys_defs;
   localparam int CDB_NUM_REQ = 8;
   localparam int CDB_NUM     = 2;
   localparam int CDB_TAG_W   = 6;
   localparam int CDB_DATA_W  = 32;
   localparam int CDB_CNT_W   = 16;

   typedef struct packed {
      logic                  valid;
      logic [CDB_TAG_W-1:0]  tag;
      logic [CDB_DATA_W-1:0] data;
   } cdb_packet_t;

   // Modular add for idx, step < n; avoids a divider for non-power-of-2 requester counts.
   function automatic int wrap_inc(int idx, int step, int n);
      int sum;
      sum = idx + step;
      return (sum >= n) ? sum - n : sum;
   endfunction
endpackage

// File: rtl/cdb_rr_arbiter_if.sv
// Requester / CDB bus bundle for cdb_rr_arbiter.
// master = FU result stages and CDB consumers, slave = the arbiter.
interface cdb_rr_arbiter_if
   import sys_defs::*;
#(
   parameter int NUM_REQ = CDB_NUM_REQ,
   parameter int NUM_CDB = CDB_NUM,
   parameter int TAG_W   = CDB_TAG_W,
   parameter int DATA_W  = CDB_DATA_W
);
   logic                           squash;
   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]             req_ready;
   logic [NUM_CDB-1:0]             cdb_valid;
   logic [NUM_CDB-1:0][TAG_W-1:0]  cdb_tag;
   logic [NUM_CDB-1:0][DATA_W-1:0] cdb_data;

   modport master (
      output squash, req_valid, req_tag, req_data,
      input  req_ready, cdb_valid, cdb_tag, cdb_data
   );

   modport slave (
      input  squash, req_valid, req_tag, req_data,
      output req_ready, cdb_valid, cdb_tag, cdb_data
   );
endinterface

// File: rtl/cdb_rr_arbiter_pick.sv
// cdb_rr_pick: combinational round-robin multi-grant picker. Rotates req_valid by rr_ptr,
// takes the first NUM_CDB set bits in scan order, and returns un-rotated per-lane one-hot grants.
module cdb_rr_pick
   import sys_defs::*;
#(
   parameter int NUM_REQ = CDB_NUM_REQ,
   parameter int NUM_CDB = CDB_NUM
) (
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [$clog2(NUM_REQ)-1:0]      rr_ptr,
   output logic [NUM_CDB-1:0][NUM_REQ-1:0] lane_gnt,
   output logic                            any_gnt,
   output logic [$clog2(NUM_REQ)-1:0]      last_idx
);
   localparam int PTR_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] rot_valid;
   logic [NUM_REQ-1:0] remaining;
   logic               found;
   int                 orig;

   always_comb begin
      rot_valid = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         rot_valid[j] = req_valid[wrap_inc(j, int'(rr_ptr), NUM_REQ)];
      end
   end

   // Lane k takes the k-th surviving bit; the last assignment made is the last winner.
   always_comb begin
      lane_gnt  = '0;
      any_gnt   = 1'b0;
      last_idx  = '0;
      remaining = rot_valid;
      found     = 1'b0;
      orig      = 0;
      for (int k = 0; k < NUM_CDB; k++) begin
         found = 1'b0;
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && remaining[j]) begin
               found             = 1'b1;
               remaining[j]      = 1'b0;
               orig              = wrap_inc(j, int'(rr_ptr), NUM_REQ);
               lane_gnt[k][orig] = 1'b1;
               any_gnt           = 1'b1;
               last_idx          = PTR_W'(orig);
            end
         end
      end
   end
endmodule

// File: rtl/cdb_rr_arbiter.sv
// cdb_rr_arbiter: grants up to NUM_CDB completion requesters per cycle in round-robin order and
// registers the winners onto the CDB lanes. Macro CDB_PERF_EN adds saturating grant/stall counters.
module cdb_rr_arbiter
   import sys_defs::*;
#(
   parameter int NUM_REQ = CDB_NUM_REQ,
   parameter int NUM_CDB = CDB_NUM,
   parameter int TAG_W   = CDB_TAG_W,
   parameter int DATA_W  = CDB_DATA_W,
   parameter int CNT_W   = CDB_CNT_W
) (
   input  logic                          clock,
   input  logic                          reset_n,
`ifdef CDB_PERF_EN
   output logic [NUM_REQ-1:0][CNT_W-1:0] perf_grant_cnt,
   output logic [CNT_W-1:0]              perf_stall_cnt,
`endif
   cdb_rr_arbiter_if.slave               bus
);
   localparam int PTR_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2) begin : g_bad_num_req
      $error("cdb_rr_arbiter: NUM_REQ must be at least 2");
   end
   if (NUM_CDB < 1 || NUM_CDB > NUM_REQ) begin : g_bad_num_cdb
      $error("cdb_rr_arbiter: NUM_CDB must lie within 1..NUM_REQ");
   end
   // Lane registers use the shared packet type, so tag/data widths are pinned to the package.
   if (TAG_W != CDB_TAG_W || DATA_W != CDB_DATA_W) begin : g_bad_pkt
      $error("cdb_rr_arbiter: TAG_W/DATA_W must match sys_defs packet widths");
   end
   if (CNT_W < 1) begin : g_bad_cnt
      $error("cdb_rr_arbiter: CNT_W must be at least 1");
   end

   logic [NUM_CDB-1:0][NUM_REQ-1:0] lane_gnt;
   logic                            any_gnt;
   logic [PTR_W-1:0]                last_idx;
   logic [NUM_REQ-1:0]              gnt_req;
   logic                            grant_en;
   logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
   cdb_packet_t [NUM_CDB-1:0]       cdb_q, cdb_d;

   cdb_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .NUM_CDB (NUM_CDB)
   ) u_pick (
      .req_valid (bus.req_valid),
      .rr_ptr    (rr_ptr_q),
      .lane_gnt  (lane_gnt),
      .any_gnt   (any_gnt),
      .last_idx  (last_idx)
   );

   assign grant_en = reset_n & ~bus.squash;

   always_comb begin
      gnt_req = '0;
      for (int k = 0; k < NUM_CDB; k++) begin
         gnt_req = gnt_req | lane_gnt[k];
      end
   end

   assign bus.req_ready = grant_en ? gnt_req : '0;

   always_comb begin
      cdb_d = '0;
      for (int k = 0; k < NUM_CDB; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_en && lane_gnt[k][i]) begin
               cdb_d[k].valid = 1'b1;
               cdb_d[k].tag   = bus.req_tag[i];
               cdb_d[k].data  = bus.req_data[i];
            end
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_en && any_gnt) begin
         rr_ptr_d = PTR_W'(wrap_inc(int'(last_idx), 1, NUM_REQ));
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_q <= '0;
         cdb_q    <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         cdb_q    <= cdb_d;
      end
   end

   always_comb begin
      bus.cdb_valid = '0;
      bus.cdb_tag   = '0;
      bus.cdb_data  = '0;
      for (int k = 0; k < NUM_CDB; k++) begin
         bus.cdb_valid[k] = cdb_q[k].valid;
         bus.cdb_tag[k]   = cdb_q[k].tag;
         bus.cdb_data[k]  = cdb_q[k].data;
      end
   end

`ifdef CDB_PERF_EN
   logic [NUM_REQ-1:0][CNT_W-1:0] perf_grant_cnt_q, perf_grant_cnt_d;
   logic [CNT_W-1:0]              perf_stall_cnt_q, perf_stall_cnt_d;
   int                            valid_cnt;

   always_comb begin
      valid_cnt        = 0;
      perf_grant_cnt_d = perf_grant_cnt_q;
      perf_stall_cnt_d = perf_stall_cnt_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         valid_cnt = valid_cnt + int'(bus.req_valid[i]);
         if (bus.req_ready[i] && (perf_grant_cnt_q[i] != '1)) begin
            perf_grant_cnt_d[i] = perf_grant_cnt_q[i] + CNT_W'(1);
         end
      end
      if (!bus.squash && (valid_cnt > NUM_CDB) && (perf_stall_cnt_q != '1)) begin
         perf_stall_cnt_d = perf_stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         perf_grant_cnt_q <= '0;
         perf_stall_cnt_q <= '0;
      end else begin
         perf_grant_cnt_q <= perf_grant_cnt_d;
         perf_stall_cnt_q <= perf_stall_cnt_d;
      end
   end

   assign perf_grant_cnt = perf_grant_cnt_q;
   assign perf_stall_cnt = perf_stall_cnt_q;
`endif
endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Directed self-checking bench for cdb_rr_arbiter (NUM_REQ=8, NUM_CDB=2).
// With CDB_PERF_EN defined, CNT_W is shrunk to 4 so counter saturation is reachable quickly.
module tb_cdb_rr_arbiter;
   localparam int NUM_REQ = 8;
   localparam int NUM_CDB = 2;
   localparam int TAG_W   = 6;
   localparam int DATA_W  = 32;
`ifdef CDB_PERF_EN
   localparam int CNT_W   = 4;
`else
   localparam int CNT_W   = 16;
`endif

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

`ifdef CDB_PERF_EN
   logic [NUM_REQ-1:0][CNT_W-1:0] perf_grant_cnt;
   logic [CNT_W-1:0]              perf_stall_cnt;
`endif

   cdb_rr_arbiter_if #(
      .NUM_REQ (NUM_REQ), .NUM_CDB (NUM_CDB), .TAG_W (TAG_W), .DATA_W (DATA_W)
   ) bus ();

   cdb_rr_arbiter #(
      .NUM_REQ (NUM_REQ), .NUM_CDB (NUM_CDB), .TAG_W (TAG_W), .DATA_W (DATA_W), .CNT_W (CNT_W)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
`ifdef CDB_PERF_EN
      .perf_grant_cnt (perf_grant_cnt),
      .perf_stall_cnt (perf_stall_cnt),
`endif
      .bus            (bus)
   );

   always #5 clock = ~clock;

   function automatic logic [TAG_W-1:0] tag_of(int i);
      return TAG_W'(i * 5 + 3);
   endfunction

   function automatic logic [DATA_W-1:0] data_of(int i);
      return 32'hC0DE_0000 + DATA_W'(i * 17);
   endfunction

   function automatic logic [NUM_REQ-1:0] bit_of(int i);
      return NUM_REQ'(1) << i;
   endfunction

   task automatic drive(input logic [NUM_REQ-1:0] v, input logic s);
      @(negedge clock);
      bus.req_valid = v;
      bus.squash    = s;
      #1;
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      reset_n       = 1'b0;
      bus.req_valid = 8'hFF;
      bus.squash    = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      #1;
      checks++;
      if (bus.req_ready !== 8'h00) begin
         failures++; $display("FAIL reset_ready: got %h expected %h", bus.req_ready, 8'h00);
      end
      checks++;
      if (bus.cdb_valid !== 2'b00) begin
         failures++; $display("FAIL reset_cdb_valid: got %b expected %b", bus.cdb_valid, 2'b00);
      end
      checks++;
      if (bus.cdb_tag !== 12'h000) begin
         failures++; $display("FAIL reset_cdb_tag: got %h expected %h", bus.cdb_tag, 12'h000);
      end
      checks++;
      if (bus.cdb_data !== 64'h0) begin
         failures++; $display("FAIL reset_cdb_data: got %h expected %h", bus.cdb_data, 64'h0);
      end
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 8'h03) begin
         failures++; $display("FAIL reset_first_grant: got %h expected %h", bus.req_ready, 8'h03);
      end
      bus.req_valid = 8'h00;
   endtask

   task automatic test_round_robin;
      int                 base;
      logic [NUM_REQ-1:0] exp_rdy;
      for (int c = 0; c < 5; c++) begin
         base    = (2 * c) % NUM_REQ;
         exp_rdy = bit_of(base) | bit_of(base + 1);
         drive(8'hFF, 1'b0);
         checks++;
         if (bus.req_ready !== exp_rdy) begin
            failures++; $display("FAIL rr_ready[%0d]: got %h expected %h", c, bus.req_ready, exp_rdy);
         end
         tick;
         checks++;
         if (bus.cdb_valid !== 2'b11) begin
            failures++; $display("FAIL rr_cdb_valid[%0d]: got %b expected %b", c, bus.cdb_valid, 2'b11);
         end
         checks++;
         if (bus.cdb_tag !== {tag_of(base + 1), tag_of(base)}) begin
            failures++; $display("FAIL rr_cdb_tag[%0d]: got %h expected %h", c, bus.cdb_tag,
                                 {tag_of(base + 1), tag_of(base)});
         end
         checks++;
         if (bus.cdb_data !== {data_of(base + 1), data_of(base)}) begin
            failures++; $display("FAIL rr_cdb_data[%0d]: got %h expected %h", c, bus.cdb_data,
                                 {data_of(base + 1), data_of(base)});
         end
      end
      drive(8'h00, 1'b0);
      tick;
      checks++;
      if (bus.cdb_valid !== 2'b00) begin
         failures++; $display("FAIL rr_one_cycle_valid: got %b expected %b", bus.cdb_valid, 2'b00);
      end
      checks++;
      if (bus.cdb_tag !== 12'h000) begin
         failures++; $display("FAIL rr_idle_tag: got %h expected %h", bus.cdb_tag, 12'h000);
      end
   endtask

   task automatic test_wrap;
      drive(8'hFF, 1'b0);
      checks++;
      if (bus.req_ready !== 8'h0C) begin
         failures++; $display("FAIL wrap_pre0: got %h expected %h", bus.req_ready, 8'h0C);
      end
      tick;
      drive(8'hFF, 1'b0);
      checks++;
      if (bus.req_ready !== 8'h30) begin
         failures++; $display("FAIL wrap_pre1: got %h expected %h", bus.req_ready, 8'h30);
      end
      tick;
      drive(8'b1000_0011, 1'b0);
      checks++;
      if (bus.req_ready !== 8'h81) begin
         failures++; $display("FAIL wrap_ready: got %h expected %h", bus.req_ready, 8'h81);
      end
      tick;
      checks++;
      if (bus.cdb_valid !== 2'b11) begin
         failures++; $display("FAIL wrap_cdb_valid: got %b expected %b", bus.cdb_valid, 2'b11);
      end
      checks++;
      if (bus.cdb_tag !== {tag_of(0), tag_of(7)}) begin
         failures++; $display("FAIL wrap_cdb_tag: got %h expected %h", bus.cdb_tag, {tag_of(0), tag_of(7)});
      end
      checks++;
      if (bus.cdb_data !== {data_of(0), data_of(7)}) begin
         failures++; $display("FAIL wrap_cdb_data: got %h expected %h", bus.cdb_data, {data_of(0), data_of(7)});
      end
      drive(8'hFF, 1'b0);
      checks++;
      if (bus.req_ready !== 8'h06) begin
         failures++; $display("FAIL wrap_ptr_probe: got %h expected %h", bus.req_ready, 8'h06);
      end
      bus.req_valid = 8'h00;
   endtask

   task automatic test_single;
      drive(8'h08, 1'b0);
      checks++;
      if (bus.req_ready !== 8'h08) begin
         failures++; $display("FAIL single_ready: got %h expected %h", bus.req_ready, 8'h08);
      end
      tick;
      checks++;
      if (bus.cdb_valid !== 2'b01) begin
         failures++; $display("FAIL single_cdb_valid: got %b expected %b", bus.cdb_valid, 2'b01);
      end
      checks++;
      if (bus.cdb_tag !== {6'h00, tag_of(3)}) begin
         failures++; $display("FAIL single_cdb_tag: got %h expected %h", bus.cdb_tag, {6'h00, tag_of(3)});
      end
      checks++;
      if (bus.cdb_data !== {32'h0, data_of(3)}) begin
         failures++; $display("FAIL single_cdb_data: got %h expected %h", bus.cdb_data, {32'h0, data_of(3)});
      end
      drive(8'h00, 1'b0);
      tick;
      checks++;
      if (bus.cdb_valid !== 2'b00) begin
         failures++; $display("FAIL single_idle_valid: got %b expected %b", bus.cdb_valid, 2'b00);
      end
      drive(8'hFF, 1'b0);
      checks++;
      if (bus.req_ready !== 8'h30) begin
         failures++; $display("FAIL single_ptr_probe: got %h expected %h", bus.req_ready, 8'h30);
      end
      bus.req_valid = 8'h00;
   endtask

   task automatic test_squash;
      drive(8'hFF, 1'b0);
      checks++;
      if (bus.req_ready !== 8'h30) begin
         failures++; $display("FAIL squash_pre_ready: got %h expected %h", bus.req_ready, 8'h30);
      end
      tick;
      checks++;
      if (bus.cdb_valid !== 2'b11) begin
         failures++; $display("FAIL squash_lanes_busy: got %b expected %b", bus.cdb_valid, 2'b11);
      end
      drive(8'h0F, 1'b1);
      checks++;
      if (bus.req_ready !== 8'h00) begin
         failures++; $display("FAIL squash_ready: got %h expected %h", bus.req_ready, 8'h00);
      end
      tick;
      checks++;
      if (bus.cdb_valid !== 2'b00) begin
         failures++; $display("FAIL squash_cdb_valid: got %b expected %b", bus.cdb_valid, 2'b00);
      end
      drive(8'hFF, 1'b0);
      checks++;
      if (bus.req_ready !== 8'hC0) begin
         failures++; $display("FAIL squash_ptr_hold: got %h expected %h", bus.req_ready, 8'hC0);
      end
      bus.req_valid = 8'h00;
   endtask

   task automatic test_reset_mid;
      drive(8'hFF, 1'b0);
      tick;
      checks++;
      if (bus.cdb_valid !== 2'b11) begin
         failures++; $display("FAIL midrst_lanes_busy: got %b expected %b", bus.cdb_valid, 2'b11);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.cdb_valid !== 2'b00) begin
         failures++; $display("FAIL midrst_cdb_valid: got %b expected %b", bus.cdb_valid, 2'b00);
      end
      checks++;
      if (bus.cdb_tag !== 12'h000) begin
         failures++; $display("FAIL midrst_cdb_tag: got %h expected %h", bus.cdb_tag, 12'h000);
      end
      checks++;
      if (bus.req_ready !== 8'h00) begin
         failures++; $display("FAIL midrst_ready: got %h expected %h", bus.req_ready, 8'h00);
      end
      bus.req_valid = 8'h00;
      drive(8'h00, 1'b0);
      reset_n = 1'b1;
      drive(8'hFF, 1'b0);
      checks++;
      if (bus.req_ready !== 8'h03) begin
         failures++; $display("FAIL midrst_ptr_zero: got %h expected %h", bus.req_ready, 8'h03);
      end
      bus.req_valid = 8'h00;
   endtask

`ifdef CDB_PERF_EN
   task automatic test_perf;
      int sum;
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         drive(8'h07, 1'b0);
         tick;
      end
      sum = 0;
      for (int i = 0; i < NUM_REQ; i++) sum = sum + int'(perf_grant_cnt[i]);
      checks++;
      if (perf_stall_cnt !== CNT_W'(10)) begin
         failures++; $display("FAIL perf_stall_10: got %0d expected %0d", perf_stall_cnt, 10);
      end
      checks++;
      if (sum != 20) begin
         failures++; $display("FAIL perf_grant_sum: got %0d expected %0d", sum, 20);
      end
      for (int c = 0; c < 20; c++) begin
         drive(8'h07, 1'b0);
         tick;
      end
      checks++;
      if (perf_stall_cnt !== CNT_W'(15)) begin
         failures++; $display("FAIL perf_stall_sat: got %0d expected %0d", perf_stall_cnt, 15);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (perf_grant_cnt[i] !== CNT_W'(15)) begin
            failures++; $display("FAIL perf_grant_sat[%0d]: got %0d expected %0d", i, perf_grant_cnt[i], 15);
         end
      end
      bus.req_valid = 8'h00;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   initial begin
      bus.squash    = 1'b0;
      bus.req_valid = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_tag[i]  = tag_of(i);
         bus.req_data[i] = data_of(i);
      end
      test_reset;
      test_round_robin;
      test_wrap;
      test_single;
      test_squash;
      test_reset_mid;
`ifdef CDB_PERF_EN
      test_perf;
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
